// File: rtl/sw_debounce.sv
// Per-bit synchronizer plus debouncer for raw board switches; emits a clean bus and change strobes.
// Define SW_DEBOUNCE_EDGE_EN to add the o_rise/o_fall edge strobe outputs.
module sw_debounce #(
  parameter int unsigned NSW             = 9,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter int          CW              = 17
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NSW-1:0] i_sw,
  output logic [NSW-1:0] o_sw,
  output logic [NSW-1:0] o_changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [NSW-1:0] o_rise,
  output logic [NSW-1:0] o_fall
`endif
);

  // Elaboration-time legality checks
  if (DEBOUNCE_CYCLES < 1) begin : gen_bad_cycles
    $error("sw_debounce: DEBOUNCE_CYCLES must be 1 or more");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_sync
    $error("sw_debounce: SYNC_STAGES must be 2 or more");
  end
  if (CW < 1 || (CW < 63 && DEBOUNCE_CYCLES > 1 &&
                 longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CW))) begin : gen_bad_cw
    $error("sw_debounce: CW too narrow for DEBOUNCE_CYCLES-1");
  end

  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    StStable,
    StCounting
  } state_e;

  logic [NSW-1:0] sync_q [SYNC_STAGES];
  logic [NSW-1:0] s;

  state_e         state_q [NSW];
  logic [CW-1:0]  cnt_q   [NSW];
  logic [NSW-1:0] sw_q;
  logic [NSW-1:0] changed_q;
  logic [NSW-1:0] rise_q;
  logic [NSW-1:0] fall_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= i_sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // One FSM + counter per bit; bits never interact.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < int'(NSW); k++) begin
        state_q[k] <= StStable;
        cnt_q[k]   <= '0;
      end
      sw_q      <= '0;
      changed_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      for (int k = 0; k < int'(NSW); k++) begin
        changed_q[k] <= 1'b0;
        rise_q[k]    <= 1'b0;
        fall_q[k]    <= 1'b0;
        case (state_q[k])
          StStable: begin
            if (s[k] != sw_q[k]) begin
              if (DEBOUNCE_CYCLES == 1) begin
                sw_q[k]      <= s[k];
                changed_q[k] <= 1'b1;
                rise_q[k]    <= s[k];
                fall_q[k]    <= ~s[k];
                cnt_q[k]     <= '0;
              end else begin
                cnt_q[k]   <= CW'(1);
                state_q[k] <= StCounting;
              end
            end
          end
          StCounting: begin
            if (s[k] == sw_q[k]) begin
              // Glitch rejected: restart from a clean count, no strobe.
              cnt_q[k]   <= '0;
              state_q[k] <= StStable;
            end else if (cnt_q[k] == CntMax) begin
              sw_q[k]      <= s[k];
              changed_q[k] <= 1'b1;
              rise_q[k]    <= s[k];
              fall_q[k]    <= ~s[k];
              cnt_q[k]     <= '0;
              state_q[k]   <= StStable;
            end else begin
              cnt_q[k] <= cnt_q[k] + CW'(1);
            end
          end
          default: begin
            cnt_q[k]   <= '0;
            state_q[k] <= StStable;
          end
        endcase
      end
    end
  end

  assign o_sw      = sw_q;
  assign o_changed = changed_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  logic unused_edge;
  assign unused_edge = ^{rise_q, fall_q};
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed literal checks plus randomized traffic
// compared every cycle against a sample-window reference model.
module tb_sw_debounce;

  localparam int unsigned NSW = 9;
  localparam int          SS  = 2;
  localparam int          DC  = 4;
  localparam int          CW  = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NSW-1:0] i_sw = '0;
  logic [NSW-1:0] o_sw;
  logic [NSW-1:0] o_changed;
  logic [NSW-1:0] o_rise;
  logic [NSW-1:0] o_fall;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  sw_debounce #(
    .NSW(NSW),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .CW(CW)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_sw(i_sw),
    .o_sw(o_sw),
    .o_changed(o_changed)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .o_rise(o_rise),
    .o_fall(o_fall)
`endif
  );

`ifndef SW_DEBOUNCE_EDGE_EN
  assign o_rise = '0;
  assign o_fall = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a bit flips when the FSM-visible samples of the last DC edges
  // all disagree with the reported value. Visible sample = i_sw captured SS edges earlier.
  logic [NSW-1:0] cap [$];
  logic [NSW-1:0] hist [$];
  logic [NSW-1:0] m_sw, m_chg, m_rise, m_fall;

  task automatic model_clear();
    cap.delete();
    hist.delete();
    for (int j = 0; j <= SS; j++) cap.push_front('0);
    for (int j = 0; j < DC; j++) hist.push_front('0);
    m_sw   = '0;
    m_chg  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else begin
      cap.push_front(i_sw);
      void'(cap.pop_back());
      hist.push_front(cap[SS]);
      void'(hist.pop_back());
      m_chg  = '0;
      m_rise = '0;
      m_fall = '0;
      for (int k = 0; k < int'(NSW); k++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++) begin
          if (hist[j][k] == m_sw[k]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_chg[k]  = 1'b1;
          m_rise[k] = ~m_sw[k];
          m_fall[k] = m_sw[k];
          m_sw[k]   = ~m_sw[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_o_sw", 32'(o_sw), 32'(m_sw));
      check("model_o_changed", 32'(o_changed), 32'(m_chg));
`ifdef SW_DEBOUNCE_EDGE_EN
      check("model_o_rise", 32'(o_rise), 32'(m_rise));
      check("model_o_fall", 32'(o_fall), 32'(m_fall));
      check("rise_and_fall_exclusive", 32'(o_rise & o_fall), 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic bseq [6];
    int   n_r, n_f;
    bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    model_clear();
    rst = 1'b1;
    i_sw = '0;
    tick();
    check_en = 1'b1;
    check("reset_o_sw", 32'(o_sw), 32'd0);
    check("reset_o_changed", 32'(o_changed), 32'd0);

    // All switches high while in reset; full latency after release
    i_sw = 9'h1FF;
    #3 rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("allhigh_edge%0d_o_sw", e), 32'(o_sw), 32'h000);
    end
    tick();
    check("allhigh_edge6_o_sw", 32'(o_sw), 32'h1FF);
    check("allhigh_edge6_o_changed", 32'(o_changed), 32'h1FF);
    tick();
    check("allhigh_edge7_o_changed", 32'(o_changed), 32'h000);

    i_sw = '0;
    repeat (8) tick();
    check("allhigh_back_low", 32'(o_sw), 32'h000);

    // 3-cycle pulse on bit 3 must be rejected
    i_sw[3] = 1'b1;
    repeat (3) tick();
    i_sw[3] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("glitch3_o_sw", 32'(o_sw), 32'h000);
      check("glitch3_o_changed", 32'(o_changed), 32'h000);
    end
    check("glitch3_cnt", 32'(dut.cnt_q[3]), 32'd0);

    // Bounce on bit 0 restarts the count
    for (int i = 0; i < 6; i++) begin
      i_sw[0] = bseq[i];
      tick();
    end
    tick();
    check("bounce0_early_o_sw", 32'(o_sw), 32'h000);
    tick();
    check("bounce0_o_sw", 32'(o_sw), 32'h001);
    check("bounce0_o_changed", 32'(o_changed), 32'h001);

    // Simultaneous rise on bit 8 and fall on bit 5
    i_sw = 9'h020;
    repeat (10) tick();
    check("pre_simul_o_sw", 32'(o_sw), 32'h020);
    i_sw = 9'h100;
    repeat (5) tick();
    check("simul_edge5_o_sw", 32'(o_sw), 32'h020);
    tick();
    check("simul_edge6_o_sw", 32'(o_sw), 32'h100);
    check("simul_edge6_o_changed", 32'(o_changed), 32'h120);

    // Asynchronous reset mid-count
    i_sw = 9'h101;
    repeat (4) tick();
    check("midcount_cnt0", 32'(dut.cnt_q[0]), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_o_sw", 32'(o_sw), 32'h000);
    check("async_rst_o_changed", 32'(o_changed), 32'h000);
    check("async_rst_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    #3 rst = 1'b0;
    repeat (5) tick();
    check("post_rst_edge5_o_sw", 32'(o_sw), 32'h000);
    tick();
    check("post_rst_edge6_o_sw", 32'(o_sw), 32'h101);
    check("post_rst_edge6_o_changed", 32'(o_changed), 32'h101);

`ifdef SW_DEBOUNCE_EDGE_EN
    n_r = 0;
    n_f = 0;
    i_sw[1] = 1'b1;
    repeat (8) begin
      tick();
      n_r += int'(o_rise[1]);
      n_f += int'(o_fall[1]);
    end
    i_sw[1] = 1'b0;
    repeat (8) begin
      tick();
      n_r += int'(o_rise[1]);
      n_f += int'(o_fall[1]);
    end
    check("edge1_rise_count", 32'(n_r), 32'd1);
    check("edge1_fall_count", 32'(n_f), 32'd1);
`else
    n_r = 0;
    n_f = 0;
`endif

    // Randomized traffic at several toggle rates, with rare async resets
    for (int phase = 0; phase < 3; phase++) begin
      int rate;
      rate = (phase == 0) ? 3 : ((phase == 1) ? 8 : 20);
      for (int c = 0; c < 1500; c++) begin
        for (int k = 0; k < int'(NSW); k++) begin
          if ($urandom_range(rate - 1) == 0) i_sw[k] = ~i_sw[k];
        end
        if ($urandom_range(499) == 0) begin
          rst = 1'b1;
          tick();
          #1 rst = 1'b0;
        end
        tick();
      end
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
